// File: rtl/spu_forward_writeback_if.sv
// Result, operand-read and write-back bundle between the execution units,
// register fetch and the register file.
interface spu_forward_writeback_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
);
    logic              stall;
    logic              resultWrite1;
    logic [ADDR_W-1:0] resultRT1;
    logic [DATA_W-1:0] resultData1;
    logic              resultWrite2;
    logic [ADDR_W-1:0] resultRT2;
    logic [DATA_W-1:0] resultData2;

    logic [ADDR_W-1:0] readRegisterRA_REG1, readRegisterRA_REG2;
    logic [ADDR_W-1:0] readRegisterRB_REG1, readRegisterRB_REG2;
    logic [ADDR_W-1:0] readRegisterRC_REG1, readRegisterRC_REG2;
    logic [DATA_W-1:0] readDataRA_REG1, readDataRA_REG2;
    logic [DATA_W-1:0] readDataRB_REG1, readDataRB_REG2;
    logic [DATA_W-1:0] readDataRC_REG1, readDataRC_REG2;
    logic [DATA_W-1:0] fwdDataRA_REG1, fwdDataRA_REG2;
    logic [DATA_W-1:0] fwdDataRB_REG1, fwdDataRB_REG2;
    logic [DATA_W-1:0] fwdDataRC_REG1, fwdDataRC_REG2;

    logic [ADDR_W-1:0] readRegisterRT_WB1, readRegisterRT_WB2;
    logic [DATA_W-1:0] writeData_WB1, writeData_WB2;
    logic              regWriteEnable_WB1, regWriteEnable_WB2;

    modport slave (
        input  stall, resultWrite1, resultRT1, resultData1,
               resultWrite2, resultRT2, resultData2,
               readRegisterRA_REG1, readRegisterRA_REG2,
               readRegisterRB_REG1, readRegisterRB_REG2,
               readRegisterRC_REG1, readRegisterRC_REG2,
               readDataRA_REG1, readDataRA_REG2,
               readDataRB_REG1, readDataRB_REG2,
               readDataRC_REG1, readDataRC_REG2,
        output fwdDataRA_REG1, fwdDataRA_REG2,
               fwdDataRB_REG1, fwdDataRB_REG2,
               fwdDataRC_REG1, fwdDataRC_REG2,
               readRegisterRT_WB1, readRegisterRT_WB2,
               writeData_WB1, writeData_WB2,
               regWriteEnable_WB1, regWriteEnable_WB2
    );

    modport master (
        output stall, resultWrite1, resultRT1, resultData1,
               resultWrite2, resultRT2, resultData2,
               readRegisterRA_REG1, readRegisterRA_REG2,
               readRegisterRB_REG1, readRegisterRB_REG2,
               readRegisterRC_REG1, readRegisterRC_REG2,
               readDataRA_REG1, readDataRA_REG2,
               readDataRB_REG1, readDataRB_REG2,
               readDataRC_REG1, readDataRC_REG2,
        input  fwdDataRA_REG1, fwdDataRA_REG2,
               fwdDataRB_REG1, fwdDataRB_REG2,
               fwdDataRC_REG1, fwdDataRC_REG2,
               readRegisterRT_WB1, readRegisterRT_WB2,
               writeData_WB1, writeData_WB2,
               regWriteEnable_WB1, regWriteEnable_WB2
    );
endinterface

// File: rtl/spu_forward_writeback.sv
// Dual-issue result pipeline with operand forwarding and register write-back.
// Latency: result captured at edge N drives write-back after edge N+DEPTH-1; forwarding is combinational.
// Backpressure: stall freezes every stage, ignores new results and masks write enables.
module spu_forward_writeback #(
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input logic                    clk,
    input logic                    reset,
    spu_forward_writeback_if.slave bus
);
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] rt;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t pipe_q [2][DEPTH];
    entry_t pipe_d [2][DEPTH];
    entry_t in_dat [2];

    logic [ADDR_W-1:0] rd_addr [6];
    logic [DATA_W-1:0] rd_dat  [6];
    logic [DATA_W-1:0] fwd_dat [6];

    assign in_dat[0] = '{vld: bus.resultWrite1, rt: bus.resultRT1, dat: bus.resultData1};
    assign in_dat[1] = '{vld: bus.resultWrite2, rt: bus.resultRT2, dat: bus.resultData2};

    always_comb begin
        pipe_d = pipe_q;
        if (!bus.stall) begin
            for (int s = 0; s < 2; s++) begin
                pipe_d[s][0] = in_dat[s];
                for (int k = 1; k < DEPTH; k++) begin
                    pipe_d[s][k] = pipe_q[s][k-1];
                end
            end
        end
    end

    // Reset takes precedence over stall and over any incoming result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    pipe_q[s][k] <= '0;
                end
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign bus.readRegisterRT_WB1 = pipe_q[0][DEPTH-1].rt;
    assign bus.writeData_WB1      = pipe_q[0][DEPTH-1].dat;
    assign bus.regWriteEnable_WB1 = pipe_q[0][DEPTH-1].vld & ~bus.stall;
    assign bus.readRegisterRT_WB2 = pipe_q[1][DEPTH-1].rt;
    assign bus.writeData_WB2      = pipe_q[1][DEPTH-1].dat;
    assign bus.regWriteEnable_WB2 = pipe_q[1][DEPTH-1].vld & ~bus.stall;

    assign rd_addr[0] = bus.readRegisterRA_REG1;
    assign rd_addr[1] = bus.readRegisterRA_REG2;
    assign rd_addr[2] = bus.readRegisterRB_REG1;
    assign rd_addr[3] = bus.readRegisterRB_REG2;
    assign rd_addr[4] = bus.readRegisterRC_REG1;
    assign rd_addr[5] = bus.readRegisterRC_REG2;
    assign rd_dat[0]  = bus.readDataRA_REG1;
    assign rd_dat[1]  = bus.readDataRA_REG2;
    assign rd_dat[2]  = bus.readDataRB_REG1;
    assign rd_dat[3]  = bus.readDataRB_REG2;
    assign rd_dat[4]  = bus.readDataRC_REG1;
    assign rd_dat[5]  = bus.readDataRC_REG2;

    // Scan oldest to youngest, slot 1 then slot 2, so the last match is the youngest slot-2 hit.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            fwd_dat[i] = rd_dat[i];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                for (int s = 0; s < 2; s++) begin
                    if (pipe_q[s][k].vld && (pipe_q[s][k].rt == rd_addr[i])) begin
                        fwd_dat[i] = pipe_q[s][k].dat;
                    end
                end
            end
        end
    end

    assign bus.fwdDataRA_REG1 = fwd_dat[0];
    assign bus.fwdDataRA_REG2 = fwd_dat[1];
    assign bus.fwdDataRB_REG1 = fwd_dat[2];
    assign bus.fwdDataRB_REG2 = fwd_dat[3];
    assign bus.fwdDataRC_REG1 = fwd_dat[4];
    assign bus.fwdDataRC_REG2 = fwd_dat[5];
endmodule

// File: doc/spu_forward_writeback.md
Name: spu_forward_writeback

Overview:
- Dual-issue result pipeline between the execution units and the register fetch stage.
- Each issue slot (1 = first instruction, 2 = second instruction) carries its result through a DEPTH-stage shift pipeline, then drives the register file write-back ports.
- Every in-flight result is forwarded to the six register-fetch operand reads (RA/RB/RC, slots 1 and 2), so dependent instructions read correct values before write-back.

Parameters:
- DEPTH, 7, number of result pipeline stages; stage DEPTH drives write-back; legal range 1..8.
- DATA_W, 128, register/result width.
- ADDR_W, 7, register address width (128 registers).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- stall  input  1  freeze pipeline; suppress write-back
- resultWrite1  input  1  slot-1 result valid and writes a register
- resultRT1  input  ADDR_W  slot-1 destination register
- resultData1  input  DATA_W  slot-1 result value
- resultWrite2  input  1  slot-2 result valid and writes a register
- resultRT2  input  ADDR_W  slot-2 destination register
- resultData2  input  DATA_W  slot-2 result value
- readRegisterRA_REG1, readRegisterRA_REG2, readRegisterRB_REG1, readRegisterRB_REG2, readRegisterRC_REG1, readRegisterRC_REG2  input  ADDR_W each  operand addresses presented to the register file
- readDataRA_REG1 … readDataRC_REG2 (six)  input  DATA_W each  raw register file read data
- fwdDataRA_REG1 … fwdDataRC_REG2 (six)  output  DATA_W each  operand values after forwarding
- readRegisterRT_WB1, readRegisterRT_WB2  output  ADDR_W  write-back destination
- writeData_WB1, writeData_WB2  output  DATA_W  write-back data
- regWriteEnable_WB1, regWriteEnable_WB2  output  1  write-back enables

Behaviour:
- State per slot s ∈ {1,2} and per stage k = 1..DEPTH: valid, rt, data.
- Reset (reset==0 at rising edge):
  - all valid cleared; rt and data cleared to 0.
  - Write-back outputs read 0 the following cycle.
  - Reset wins over stall and over incoming results. In-flight results are discarded, never written back.
- Normal advance (reset==1, stall==0), per rising edge:
  - stage 1 ← {resultWrite_s, resultRT_s, resultData_s}.
  - stage k ← stage k-1 for k = 2..DEPTH.
  - Stage DEPTH contents are discarded after their write-back cycle.
- Stall (stall==1): all stages hold.
  - Incoming results are not captured; the producer must hold them.
  - No bubble is inserted.
- Write-back outputs:
  - readRegisterRT_WBs and writeData_WBs = stage DEPTH rt/data of slot s, directly from registers.
  - regWriteEnable_WBs = valid_DEPTH,s & ~stall.
  - Latency: a result presented at edge N is written back in the cycle after edge N+DEPTH-1, assuming no stall.
  - A held entry writes exactly once, after stall drops.
- Same-register write-back from both slots in one cycle: both enables assert; the register file applies slot 2 last, so slot 2 is architecturally final.
- Forwarding: combinational, evaluated independently for each of the six operand ports with address a.
  - Search order k = 1 (youngest) to DEPTH (oldest); within a stage, slot 2 before slot 1.
  - The first entry with valid && rt == a supplies data.
  - No hit: the operand output equals the corresponding readData input.
  - Inputs not yet captured (resultWrite this cycle) are never forwarded.
  - Forwarding is active during stall and ignores stall.
- resultWrite_s == 0 entries still shift, but never forward or write.
- Register 0 gets no special treatment.
- No flush; the pipeline drains only by advancing or by reset.

Test Plan:
- Latency, DEPTH=7: slot 1 writes RT=5, data=0xA5…A5 at edge 0 → regWriteEnable_WB1=1, RT_WB1=5, writeData_WB1=0xA5…A5 only in the cycle after edge 6; 0 otherwise.
- Forwarding: RT=10=0x1111 in stage 3; readRegisterRB_REG2=10, readDataRB_REG2=0xDEAD → fwdDataRB_REG2=0x1111. Address 11 passes through readData unchanged.
- Priority:
  - RT=20=0x1 in stage 4 (slot 2) and RT=20=0x2 in stage 2 (slot 1) → forward 0x2.
  - Same stage, both slots RT=20 (0x3 slot 1, 0x4 slot 2) → forward 0x4.
  - At write-back, both enables high with RT=20.
- Stall: entry in stage DEPTH, stall=1 for 3 cycles while resultWrite1=1 → regWriteEnable_WB1=0 throughout, stage contents unchanged, stalled inputs absent. After release, exactly one write.
- Reset mid-operation: entries in stages 1..DEPTH, reset=0 for one edge → all write enables 0 and all forwarding misses; no stale write afterward.
- Combined stall + reset on same edge → reset result (all clear).
